// File: rtl/lam_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP16 log-approximate multiplier among NREQ requesters.
// Optional LAM_ZERO_BYPASS_EN: operations with a +/-0 operand skip the core and respond directly.
module lam_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic                 mul_start,
   output logic [15:0]          mul_a,
   output logic [15:0]          mul_b,
   input  logic                 mul_done,
   input  logic [15:0]          mul_result,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_data,
   output logic                 busy,
   output logic [15:0]          op_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and ready here only depends on state and req_valid.

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nx;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] winner;
   logic            found;
   logic [ID_W:0]   cand;
   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic            zero_op;

   // Search starts just past the last served requester and wraps modulo NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_a = req_a[16*winner +: 16];
      sel_b = req_b[16*winner +: 16];
   end

`ifdef LAM_ZERO_BYPASS_EN
   assign zero_op = (sel_a[14:0] == 15'd0) || (sel_b[14:0] == 15'd0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      mul_start = 1'b0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
               state_nx  = zero_op ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            mul_start = 1'b1;
            state_nx  = WAIT;
         end
         WAIT: begin
            if (mul_done) state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= ID_W'(NREQ-1);
         mul_a    <= '0;
         mul_b    <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  mul_a  <= sel_a;
                  mul_b  <= sel_b;
                  rsp_id <= winner;
                  if (zero_op) rsp_data <= {sel_a[15] ^ sel_b[15], 15'd0};
               end
            end
            WAIT: begin
               if (mul_done) rsp_data <= mul_result;
            end
            RESP: begin
               if (rsp_ready) begin
                  rr_ptr   <= rsp_id;
                  op_count <= op_count + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lam_mul_arbiter.sv
// Self-checking bench for lam_mul_arbiter: vector table, directed corner sequences and a
// randomized phase against a transaction-level round-robin model with a fixed-latency core.
module tb_lam_mul_arbiter;
   localparam int NREQ = 4;
   localparam int ID_W = 2;
   localparam int L    = 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_a = '0;
   logic [16*NREQ-1:0]  req_b = '0;
   logic                mul_start;
   logic [15:0]         mul_a;
   logic [15:0]         mul_b;
   logic                mul_done;
   logic [15:0]         mul_result = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [ID_W-1:0]     rsp_id;
   logic [15:0]         rsp_data;
   logic                busy;
   logic [15:0]         op_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ops = 0;
   logic [ID_W+15:0] exp_q[$];

   always #5 clk = ~clk;

   lam_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_result(mul_result), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
      .op_count(op_count)
   );

   // Log-domain product: add biased exponent/mantissa fields, subtract one bias.
   function automatic logic [15:0] lam(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] s;
      s = {1'b0, a[14:0]} + {1'b0, b[14:0]} - 16'h3C00;
      return {a[15] ^ b[15], s[14:0]};
   endfunction

   function automatic bit is_bypass(input logic [15:0] a, input logic [15:0] b);
`ifdef LAM_ZERO_BYPASS_EN
      return (a[14:0] == 15'd0) || (b[14:0] == 15'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] exp_data(input logic [15:0] a, input logic [15:0] b);
      if (is_bypass(a, b)) return {a[15] ^ b[15], 15'd0};
      return lam(a, b);
   endfunction

   function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
      return is_bypass(a, b) ? 1 : L + 2;
   endfunction

   function automatic int model_winner(input logic [NREQ-1:0] v, input int last);
      int j;
      for (int k = 1; k <= NREQ; k++) begin
         j = (last + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   // Fixed-latency core: done strobe L cycles after the start pulse; not reset by rst_n.
   logic        core_done = 1'b0;
   logic        spur_done = 1'b0;
   int unsigned cyc = 0;
   int unsigned done_at = 32'hFFFF_FFFF;
   logic [15:0] la = '0;
   logic [15:0] lb = '0;
   assign mul_done = core_done | spur_done;

   always @(negedge clk) begin
      cyc++;
      core_done = (cyc == done_at);
      if (core_done) mul_result = lam(la, lb);
      if (mul_start) begin
         done_at = cyc + L;
         la = mul_a;
         lb = mul_b;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ops = 0;
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 40 && !idle; k++) begin
         @(negedge clk);
         if (!busy) idle = 1'b1;
      end
      check("drain_idle", 32'(idle), 32'd1);
   endtask

   task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input bit spur_issue);
      bit got;
      bit seen;
      int lat;
      int starts;
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[16*id +: 16] = a;
      req_b[16*id +: 16] = b;
      rsp_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      check("op_grant", 32'(got), 32'd1);
      if (!got) return;
      check("op_ready_onehot", 32'(req_ready), 32'd1 << id);
      @(posedge clk); #1;
      req_valid = '0;
      if (spur_issue) spur_done = 1'b1;
      seen = 1'b0; lat = 0; starts = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (mul_start) begin
            starts++;
            check("op_mul_a", 32'(mul_a), 32'(a));
            check("op_mul_b", 32'(mul_b), 32'(b));
         end
         if (rsp_valid) seen = 1'b1;
         if (lat == 1 && spur_issue) begin
            @(posedge clk); #1;
            spur_done = 1'b0;
         end
      end
      check("op_rsp_seen", 32'(seen), 32'd1);
      check("op_latency", 32'(lat), 32'(exp_lat(a, b)));
      check("op_rsp_id", 32'(rsp_id), 32'(id));
      check("op_rsp_data", 32'(rsp_data), 32'(exp_d));
      check("op_starts", 32'(starts), is_bypass(a, b) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_ops++;
      @(negedge clk);
      check("op_count", 32'(op_count), 32'(exp_ops));
      check("op_idle", 32'(busy), 32'd0);
   endtask

   function automatic logic [15:0] rand_op();
      logic s;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) return {s, 15'd0};
      return {s, 15'($urandom_range(16'h3000, 16'h4800))};
   endfunction

   typedef struct {
      int          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_d;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [15:0]     hold_d;
      logic [NREQ-1:0] pend;
      logic [NREQ-1:0] exp_ready;
      logic [15:0]     pa[NREQ];
      logic [15:0]     pb[NREQ];
      int              waited[NREQ];
      int              order[6];
      int              last, gnt, w, g, tcyc, grant_cyc, cur_lat;
      bit              mbusy, rseen, got;
      logic [ID_W+15:0] item;

      vecs[0] = '{0, 16'h3C00, 16'h4000, 16'h4000};
      vecs[1] = '{1, 16'h4000, 16'h4000, 16'h4400};
      vecs[2] = '{2, 16'hC000, 16'h3C00, 16'hC000};
      vecs[3] = '{3, 16'h3800, 16'h3800, 16'h3400};
      vecs[4] = '{1, 16'h8000, 16'h3C00, 16'h8000};
      order   = '{0, 1, 2, 3, 0, 1};

      // Reset values.
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_d, 1'b0);

      // Spurious done in IDLE, then during ISSUE of a real operation.
      @(posedge clk); #1;
      spur_done = 1'b1;
      @(negedge clk);
      check("spur_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      spur_done = 1'b0;
      @(negedge clk);
      check("spur_idle_rsp", 32'(rsp_valid), 32'd0);
      run_op(2, 16'h4200, 16'h3E00, 16'h4400, 1'b1);

      // Response back-pressure: everything holds, no new grant, no start.
      @(posedge clk); #1;
      req_valid = 4'b0100;
      req_a[32 +: 16] = 16'h4400;
      req_b[32 +: 16] = 16'h4000;
      rsp_ready = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[2]) got = 1'b1;
      end
      check("hold_grant", 32'(got), 32'd1);
      @(posedge clk); #1;
      req_valid = 4'b1011;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      check("hold_rsp_seen", 32'(got), 32'd1);
      hold_d = lam(16'h4400, 16'h4000);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_id", 32'(rsp_id), 32'd2);
         check("hold_rsp_data", 32'(rsp_data), 32'(hold_d));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_mul_start", 32'(mul_start), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = '0;
      exp_ops++;
      @(negedge clk);
      check("hold_op_count", 32'(op_count), 32'(exp_ops));

      // All requesters valid from reset: strict rotation.
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[16*i +: 16] = 16'h3C00 + 16'(i);
         req_b[16*i +: 16] = 16'h4000;
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      g = 0;
      for (int k = 0; k < 80 && g < 6; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            check("rr_grant", 32'(req_ready), 32'd1 << order[g]);
            g++;
         end
      end
      check("rr_grants", 32'(g), 32'd6);
      @(posedge clk); #1;
      req_valid = '0;
      drain();
      check("rr_op_count", 32'(op_count), 32'd6);

      // Reset during WAIT; the late core done must be ignored.
      @(posedge clk); #1;
      req_valid = 4'b0010;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[1]) got = 1'b1;
      end
      check("rw_grant", 32'(got), 32'd1);
      @(posedge clk); #1;
      req_valid = '0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (mul_start) got = 1'b1;
      end
      check("rw_start", 32'(got), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rw_busy_rst", 32'(busy), 32'd0);
      check("rw_mul_a_rst", 32'(mul_a), 32'd0);
      #1;
      rst_n = 1'b1;
      exp_ops = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rw_no_rsp", 32'(rsp_valid), 32'd0);
         check("rw_idle", 32'(busy), 32'd0);
      end
      check("rw_op_count", 32'(op_count), 32'd0);
      @(posedge clk); #1;
      req_valid = '1;
      @(negedge clk);
      check("rw_first_grant", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = '0;
      drain();
      check("rw_op_count2", 32'(op_count), 32'd1);

      // Randomized traffic against the transaction model.
      do_reset();
      last = NREQ - 1; mbusy = 1'b0; pend = '0; gnt = -1; tcyc = 0;
      grant_cyc = 0; cur_lat = 0; rseen = 1'b0; exp_ops = 0;
      for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; waited[i] = 0; end
      for (int t = 0; t < 600; t++) begin
         @(posedge clk); #1;
         if (gnt >= 0) pend[gnt] = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (t >= 560) pend[i] = 1'b0;
            else if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1; pa[i] = rand_op(); pb[i] = rand_op(); waited[i] = 0;
            end else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
            req_a[16*i +: 16] = pa[i];
            req_b[16*i +: 16] = pb[i];
         end
         req_valid = pend;
         rsp_ready = (t >= 560) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         tcyc++;
         gnt = -1;
         exp_ready = '0;
         w = mbusy ? -1 : model_winner(pend, last);
         if (w >= 0) exp_ready[w] = 1'b1;
         check("rand_req_ready", 32'(req_ready), 32'(exp_ready));
         if (!mbusy) begin
            check("rand_idle_rsp", 32'(rsp_valid), 32'd0);
            if (w >= 0) begin
               check("rand_fair", 32'(waited[w] < NREQ), 32'd1);
               for (int j = 0; j < NREQ; j++) if (j != w && pend[j]) waited[j]++;
               gnt = w; mbusy = 1'b1; grant_cyc = tcyc; rseen = 1'b0;
               cur_lat = exp_lat(pa[w], pb[w]);
               exp_q.push_back({ID_W'(w), exp_data(pa[w], pb[w])});
            end
         end else begin
            if (rsp_valid && !rseen) begin
               rseen = 1'b1;
               check("rand_latency", 32'(tcyc - grant_cyc), 32'(cur_lat));
            end
            if (rsp_valid && rsp_ready) begin
               item = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
               check("rand_rsp_id", 32'(rsp_id), 32'(item[ID_W+15:16]));
               check("rand_rsp_data", 32'(rsp_data), 32'(item[15:0]));
               last = int'(item[ID_W+15:16]);
               mbusy = 1'b0;
               exp_ops++;
            end
         end
      end
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      check("rand_op_count", 32'(op_count), 32'(exp_ops[15:0]));
      check("rand_end_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
